per2axi_req_issue: RTL and testbench

Request-issue stage of the per2axi bridge, upstream of the response channel. Accepts single-beat 32-bit peripheral-interconnect requests, converts them to AXI4 AR or AW+W transactions (atomics included), and emits the per-ID address/atomic sideband the response channel uses to pick the 32-bit lane and suppress duplicate atomic responses. Tracks one outstanding transaction per peripheral ID.

---
 rtl/per2axi_req_issue.sv | 218 +++++++++++++++++++++
 tb/tb_per2axi_req_issue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/per2axi_req_issue.sv
// Request-issue stage of the per2axi bridge: turns single-beat peripheral requests into AXI AR or
// AW+W transactions and publishes per-ID address sideband for the response channel.
module per2axi_req_issue #(
   parameter int unsigned PER_ADDR_WIDTH = 32,
   parameter int unsigned PER_ID_WIDTH   = 5,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_USER_WIDTH = 6,
   parameter int unsigned AXI_ID_WIDTH   = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_i,

   input  logic                        per_slave_req_i,
   output logic                        per_slave_gnt_o,
   input  logic [PER_ADDR_WIDTH-1:0]   per_slave_add_i,
   input  logic                        per_slave_we_i,
   input  logic [31:0]                 per_slave_wdata_i,
   input  logic [3:0]                  per_slave_be_i,
   input  logic [5:0]                  per_slave_atop_i,
   input  logic [PER_ID_WIDTH-1:0]     per_slave_id_i,

   output logic                        axi_master_ar_valid_o,
   input  logic                        axi_master_ar_ready_i,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_master_ar_addr_o,
   output logic [2:0]                  axi_master_ar_size_o,
   output logic [AXI_ID_WIDTH-1:0]     axi_master_ar_id_o,
   output logic [AXI_USER_WIDTH-1:0]   axi_master_ar_user_o,

   output logic                        axi_master_aw_valid_o,
   input  logic                        axi_master_aw_ready_i,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_master_aw_addr_o,
   output logic [2:0]                  axi_master_aw_size_o,
   output logic [AXI_ID_WIDTH-1:0]     axi_master_aw_id_o,
   output logic [AXI_USER_WIDTH-1:0]   axi_master_aw_user_o,
   output logic [5:0]                  axi_master_aw_atop_o,

   output logic                        axi_master_w_valid_o,
   input  logic                        axi_master_w_ready_i,
   output logic [AXI_DATA_WIDTH-1:0]   axi_master_w_data_o,
   output logic [AXI_DATA_WIDTH/8-1:0] axi_master_w_strb_o,
   output logic                        axi_master_w_last_o,
   output logic [AXI_USER_WIDTH-1:0]   axi_master_w_user_o,

   output logic                        trans_req_o,
   output logic [AXI_ID_WIDTH-1:0]     trans_id_o,
   output logic [AXI_ADDR_WIDTH-1:0]   trans_add_o,

   output logic                        atop_req_o,
   output logic [AXI_ID_WIDTH-1:0]     atop_id_o,
   output logic [AXI_ADDR_WIDTH-1:0]   atop_add_o,

   input  logic                        rsp_valid_i,
   input  logic [PER_ID_WIDTH-1:0]     rsp_id_i
);

   localparam int unsigned AddrExtW = PER_ADDR_WIDTH + AXI_ADDR_WIDTH;

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e                    r_state, w_state_d;

   logic                      r_ar_valid, w_ar_valid_d;
   logic                      r_aw_valid, w_aw_valid_d;
   logic                      r_w_valid,  w_w_valid_d;
   logic                      r_trans_req, w_trans_req_d;
   logic                      r_atop_req,  w_atop_req_d;

   logic [AXI_ADDR_WIDTH-1:0] r_add;
   logic [AXI_ID_WIDTH-1:0]   r_id;
   logic [31:0]               r_wdata;
   logic [3:0]                r_be;
   logic [5:0]                r_atop;
   logic [AXI_ID_WIDTH-1:0]   r_trans_id;
   logic [AXI_ADDR_WIDTH-1:0] r_trans_add;
   logic [AXI_ID_WIDTH-1:0]   r_atop_id;
   logic [AXI_ADDR_WIDTH-1:0] r_atop_add;
   logic [PER_ID_WIDTH-1:0]   r_busy;

   logic                      w_gnt;
   logic                      w_id_busy;
   logic                      w_is_read;
   logic                      w_is_atop;
   logic [AXI_ID_WIDTH-1:0]   w_req_id;
   logic [AddrExtW-1:0]       w_add_ext;
   logic [AXI_ADDR_WIDTH-1:0] w_axi_add;
   logic [PER_ID_WIDTH-1:0]   w_busy_set;
   logic [PER_ID_WIDTH-1:0]   w_busy_clr;

   // One-hot peripheral ID to binary AXI ID.
   always_comb begin
      w_req_id = '0;
      for (int unsigned i = 0; i < PER_ID_WIDTH; i++) begin
         if (per_slave_id_i[i]) begin
            w_req_id = AXI_ID_WIDTH'(i);
         end
      end
   end

   assign w_add_ext  = AddrExtW'(per_slave_add_i);
   assign w_axi_add  = w_add_ext[AXI_ADDR_WIDTH-1:0];
   assign w_id_busy  = |(r_busy & per_slave_id_i);
   // An ATOP on a read request is ignored and the request issues as a plain read.
   assign w_is_read  = per_slave_we_i;
   assign w_is_atop  = ~per_slave_we_i & (|per_slave_atop_i);
   assign w_busy_set = w_gnt ? per_slave_id_i : '0;
   assign w_busy_clr = rsp_valid_i ? rsp_id_i : '0;

   always_comb begin
      w_state_d     = r_state;
      w_gnt         = 1'b0;
      w_ar_valid_d  = r_ar_valid & ~axi_master_ar_ready_i;
      w_aw_valid_d  = r_aw_valid & ~axi_master_aw_ready_i;
      w_w_valid_d   = r_w_valid  & ~axi_master_w_ready_i;
      w_trans_req_d = 1'b0;
      w_atop_req_d  = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_gnt = per_slave_req_i & ~w_id_busy & ~rst_i;
            if (w_gnt) begin
               w_state_d = StIssue;
               if (w_is_read) begin
                  w_ar_valid_d  = 1'b1;
                  w_trans_req_d = 1'b1;
               end else begin
                  w_aw_valid_d = 1'b1;
                  w_w_valid_d  = 1'b1;
                  w_atop_req_d = w_is_atop;
               end
            end
         end
         StIssue: begin
            if (!(w_ar_valid_d || w_aw_valid_d || w_w_valid_d)) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= StIdle;
         r_ar_valid  <= 1'b0;
         r_aw_valid  <= 1'b0;
         r_w_valid   <= 1'b0;
         r_trans_req <= 1'b0;
         r_atop_req  <= 1'b0;
         r_busy      <= '0;
      end else begin
         r_state     <= w_state_d;
         r_ar_valid  <= w_ar_valid_d;
         r_aw_valid  <= w_aw_valid_d;
         r_w_valid   <= w_w_valid_d;
         r_trans_req <= w_trans_req_d;
         r_atop_req  <= w_atop_req_d;
         r_busy      <= (r_busy & ~w_busy_clr) | w_busy_set;
      end
   end

   // Payload and sideband registers only load on grant, so they stay stable while valid is held.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_add       <= '0;
         r_id        <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_atop      <= '0;
         r_trans_id  <= '0;
         r_trans_add <= '0;
         r_atop_id   <= '0;
         r_atop_add  <= '0;
      end else if (w_gnt) begin
         r_add   <= w_axi_add;
         r_id    <= w_req_id;
         r_wdata <= per_slave_wdata_i;
         r_be    <= per_slave_be_i;
         r_atop  <= w_is_read ? 6'd0 : per_slave_atop_i;
         if (w_is_read) begin
            r_trans_id  <= w_req_id;
            r_trans_add <= w_axi_add;
         end
         if (w_is_atop) begin
            r_atop_id  <= w_req_id;
            r_atop_add <= w_axi_add;
         end
      end
   end

   assign per_slave_gnt_o       = w_gnt;

   assign axi_master_ar_valid_o = r_ar_valid;
   assign axi_master_ar_addr_o  = r_add;
   assign axi_master_ar_size_o  = 3'b010;
   assign axi_master_ar_id_o    = r_id;
   assign axi_master_ar_user_o  = '0;

   assign axi_master_aw_valid_o = r_aw_valid;
   assign axi_master_aw_addr_o  = r_add;
   assign axi_master_aw_size_o  = 3'b010;
   assign axi_master_aw_id_o    = r_id;
   assign axi_master_aw_user_o  = '0;
   assign axi_master_aw_atop_o  = r_atop;

   assign axi_master_w_valid_o  = r_w_valid;
   assign axi_master_w_data_o   = {r_wdata, r_wdata};
   assign axi_master_w_strb_o   = r_add[2] ? {r_be, 4'b0000} : {4'b0000, r_be};
   assign axi_master_w_last_o   = 1'b1;
   assign axi_master_w_user_o   = '0;

   assign trans_req_o           = r_trans_req;
   assign trans_id_o            = r_trans_id;
   assign trans_add_o           = r_trans_add;
   assign atop_req_o            = r_atop_req;
   assign atop_id_o             = r_atop_id;
   assign atop_add_o            = r_atop_add;

endmodule

// File: tb/tb_per2axi_req_issue.sv
// Directed bench for per2axi_req_issue: reset, read, write, atomic, busy stall and mid-issue reset.
module tb_per2axi_req_issue;

   logic        clk_i;
   logic        rst_i;
   logic        per_slave_req_i;
   logic        per_slave_gnt_o;
   logic [31:0] per_slave_add_i;
   logic        per_slave_we_i;
   logic [31:0] per_slave_wdata_i;
   logic [3:0]  per_slave_be_i;
   logic [5:0]  per_slave_atop_i;
   logic [4:0]  per_slave_id_i;
   logic        ar_valid, ar_ready;
   logic [31:0] ar_addr;
   logic [2:0]  ar_size, ar_id;
   logic [5:0]  ar_user;
   logic        aw_valid, aw_ready;
   logic [31:0] aw_addr;
   logic [2:0]  aw_size, aw_id;
   logic [5:0]  aw_user, aw_atop;
   logic        w_valid, w_ready, w_last;
   logic [63:0] w_data;
   logic [7:0]  w_strb;
   logic [5:0]  w_user;
   logic        trans_req_o, atop_req_o;
   logic [2:0]  trans_id_o, atop_id_o;
   logic [31:0] trans_add_o, atop_add_o;
   logic        rsp_valid_i;
   logic [4:0]  rsp_id_i;

   int checks = 0;
   int errors = 0;

   per2axi_req_issue dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .per_slave_req_i       (per_slave_req_i),
      .per_slave_gnt_o       (per_slave_gnt_o),
      .per_slave_add_i       (per_slave_add_i),
      .per_slave_we_i        (per_slave_we_i),
      .per_slave_wdata_i     (per_slave_wdata_i),
      .per_slave_be_i        (per_slave_be_i),
      .per_slave_atop_i      (per_slave_atop_i),
      .per_slave_id_i        (per_slave_id_i),
      .axi_master_ar_valid_o (ar_valid),
      .axi_master_ar_ready_i (ar_ready),
      .axi_master_ar_addr_o  (ar_addr),
      .axi_master_ar_size_o  (ar_size),
      .axi_master_ar_id_o    (ar_id),
      .axi_master_ar_user_o  (ar_user),
      .axi_master_aw_valid_o (aw_valid),
      .axi_master_aw_ready_i (aw_ready),
      .axi_master_aw_addr_o  (aw_addr),
      .axi_master_aw_size_o  (aw_size),
      .axi_master_aw_id_o    (aw_id),
      .axi_master_aw_user_o  (aw_user),
      .axi_master_aw_atop_o  (aw_atop),
      .axi_master_w_valid_o  (w_valid),
      .axi_master_w_ready_i  (w_ready),
      .axi_master_w_data_o   (w_data),
      .axi_master_w_strb_o   (w_strb),
      .axi_master_w_last_o   (w_last),
      .axi_master_w_user_o   (w_user),
      .trans_req_o           (trans_req_o),
      .trans_id_o            (trans_id_o),
      .trans_add_o           (trans_add_o),
      .atop_req_o            (atop_req_o),
      .atop_id_o             (atop_id_o),
      .atop_add_o            (atop_add_o),
      .rsp_valid_i           (rsp_valid_i),
      .rsp_id_i              (rsp_id_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [4:0] id, input logic [31:0] add,
                            input logic [31:0] wdata, input logic [3:0] be, input logic [5:0] atop);
      per_slave_req_i   = 1'b1;
      per_slave_we_i    = we;
      per_slave_id_i    = id;
      per_slave_add_i   = add;
      per_slave_wdata_i = wdata;
      per_slave_be_i    = be;
      per_slave_atop_i  = atop;
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      per_slave_req_i = 1'b1; per_slave_we_i = 1'b1; per_slave_id_i = 5'b00001;
      per_slave_add_i = '0; per_slave_wdata_i = '0; per_slave_be_i = '0; per_slave_atop_i = '0;
      ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0; rsp_valid_i = 1'b0; rsp_id_i = '0;
      tick(); tick();
      checks++; if (per_slave_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", per_slave_gnt_o); end
      checks++; if ({ar_valid, aw_valid, w_valid} !== 3'b000) begin errors++; $display("FAIL rst_valids got %b exp 000", {ar_valid, aw_valid, w_valid}); end
      checks++; if ({trans_req_o, atop_req_o} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b exp 00", {trans_req_o, atop_req_o}); end
      checks++; if ({trans_id_o, trans_add_o, atop_id_o, atop_add_o} !== 70'd0) begin errors++; $display("FAIL rst_sideband got %h exp 0", {trans_id_o, trans_add_o, atop_id_o, atop_add_o}); end
      per_slave_req_i = 1'b0;
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_read();
      ar_ready = 1'b1;
      drive_req(1'b1, 5'b00100, 32'h1004, 32'h0, 4'h0, 6'h0);
      checks++; if (per_slave_gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b exp 1", per_slave_gnt_o); end
      tick();
      per_slave_req_i = 1'b0;
      checks++; if (ar_valid !== 1'b1 || aw_valid !== 1'b0) begin errors++; $display("FAIL rd_valid got ar %b aw %b exp ar 1 aw 0", ar_valid, aw_valid); end
      checks++; if ({ar_addr, ar_id, ar_size} !== {32'h1004, 3'd2, 3'b010}) begin errors++; $display("FAIL rd_ar got addr %h id %0d size %0d exp 1004 2 2", ar_addr, ar_id, ar_size); end
      checks++; if ({trans_req_o, trans_id_o, trans_add_o} !== {1'b1, 3'd2, 32'h1004}) begin errors++; $display("FAIL rd_trans got req %b id %0d add %h exp 1 2 1004", trans_req_o, trans_id_o, trans_add_o); end
      checks++; if (atop_req_o !== 1'b0) begin errors++; $display("FAIL rd_atop got %b exp 0", atop_req_o); end
      tick();
      checks++; if ({ar_valid, trans_req_o} !== 2'b00) begin errors++; $display("FAIL rd_done got %b exp 00", {ar_valid, trans_req_o}); end
   endtask

   task automatic test_busy();
      drive_req(1'b1, 5'b00100, 32'h1010, 32'h0, 4'h0, 6'h0);
      checks++; if (per_slave_gnt_o !== 1'b0) begin errors++; $display("FAIL busy_stall got %b exp 0", per_slave_gnt_o); end
      tick();
      checks++; if (per_slave_gnt_o !== 1'b0) begin errors++; $display("FAIL busy_stall2 got %b exp 0", per_slave_gnt_o); end
      drive_req(1'b1, 5'b01000, 32'h1020, 32'h0, 4'h0, 6'h0);
      checks++; if (per_slave_gnt_o !== 1'b1) begin errors++; $display("FAIL busy_other_gnt got %b exp 1", per_slave_gnt_o); end
      tick();
      per_slave_req_i = 1'b0;
      checks++; if (ar_valid !== 1'b1 || ar_id !== 3'd3) begin errors++; $display("FAIL busy_other_ar got v %b id %0d exp 1 3", ar_valid, ar_id); end
      tick();
      drive_req(1'b1, 5'b00100, 32'h1010, 32'h0, 4'h0, 6'h0);
      rsp_valid_i = 1'b1; rsp_id_i = 5'b00100;
      #1;
      checks++; if (per_slave_gnt_o !== 1'b0) begin errors++; $display("FAIL busy_rsp_same got %b exp 0", per_slave_gnt_o); end
      tick();
      rsp_valid_i = 1'b0; rsp_id_i = '0;
      #1;
      checks++; if (per_slave_gnt_o !== 1'b1) begin errors++; $display("FAIL busy_rsp_next got %b exp 1", per_slave_gnt_o); end
      tick();
      per_slave_req_i = 1'b0;
      checks++; if ({ar_valid, ar_addr, ar_id} !== {1'b1, 32'h1010, 3'd2}) begin errors++; $display("FAIL busy_reissue got v %b addr %h id %0d exp 1 1010 2", ar_valid, ar_addr, ar_id); end
      tick();
   endtask

   task automatic test_write();
      aw_ready = 1'b0; w_ready = 1'b1;
      drive_req(1'b0, 5'b00001, 32'h2004, 32'hDEADBEEF, 4'hF, 6'h0);
      checks++; if (per_slave_gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", per_slave_gnt_o); end
      tick();
      per_slave_req_i = 1'b0;
      checks++; if ({ar_valid, aw_valid, w_valid} !== 3'b011) begin errors++; $display("FAIL wr_valids got %b exp 011", {ar_valid, aw_valid, w_valid}); end
      checks++; if (w_strb !== 8'hF0 || w_data !== 64'hDEADBEEF_DEADBEEF || w_last !== 1'b1) begin errors++; $display("FAIL wr_w got strb %h data %h last %b exp f0 deadbeefdeadbeef 1", w_strb, w_data, w_last); end
      checks++; if ({aw_addr, aw_id, aw_size, aw_atop} !== {32'h2004, 3'd0, 3'b010, 6'h0}) begin errors++; $display("FAIL wr_aw got addr %h id %0d size %0d atop %h exp 2004 0 2 0", aw_addr, aw_id, aw_size, aw_atop); end
      checks++; if ({trans_req_o, atop_req_o} !== 2'b00) begin errors++; $display("FAIL wr_pulses got %b exp 00", {trans_req_o, atop_req_o}); end
      tick();
      checks++; if ({aw_valid, w_valid} !== 2'b10) begin errors++; $display("FAIL wr_w_first got %b exp 10", {aw_valid, w_valid}); end
      drive_req(1'b1, 5'b10000, 32'h40, 32'h0, 4'h0, 6'h0);
      checks++; if (per_slave_gnt_o !== 1'b0) begin errors++; $display("FAIL wr_no_gnt_issue got %b exp 0", per_slave_gnt_o); end
      per_slave_req_i = 1'b0;
      tick();
      checks++; if (aw_valid !== 1'b1 || aw_addr !== 32'h2004) begin errors++; $display("FAIL wr_aw_hold got v %b addr %h exp 1 2004", aw_valid, aw_addr); end
      aw_ready = 1'b1;
      tick();
      checks++; if (aw_valid !== 1'b0) begin errors++; $display("FAIL wr_aw_done got %b exp 0", aw_valid); end
   endtask

   task automatic test_atomic();
      drive_req(1'b0, 5'b00010, 32'h3000, 32'h12345678, 4'h3, 6'h21);
      checks++; if (per_slave_gnt_o !== 1'b1) begin errors++; $display("FAIL at_gnt got %b exp 1 (idle after aw)", per_slave_gnt_o); end
      tick();
      per_slave_req_i = 1'b0;
      checks++; if ({aw_valid, w_valid, aw_atop, w_strb} !== {2'b11, 6'h21, 8'h03}) begin errors++; $display("FAIL at_aw got v %b%b atop %h strb %h exp 11 21 03", aw_valid, w_valid, aw_atop, w_strb); end
      checks++; if ({atop_req_o, atop_id_o, atop_add_o, trans_req_o} !== {1'b1, 3'd1, 32'h3000, 1'b0}) begin errors++; $display("FAIL at_side got req %b id %0d add %h trans %b exp 1 1 3000 0", atop_req_o, atop_id_o, atop_add_o, trans_req_o); end
      tick();
      checks++; if ({aw_valid, w_valid, atop_req_o} !== 3'b000) begin errors++; $display("FAIL at_done got %b exp 000", {aw_valid, w_valid, atop_req_o}); end
      drive_req(1'b1, 5'b10000, 32'h40, 32'h0, 4'h0, 6'h21);
      checks++; if (per_slave_gnt_o !== 1'b1) begin errors++; $display("FAIL at_rd_gnt got %b exp 1", per_slave_gnt_o); end
      tick();
      per_slave_req_i = 1'b0;
      checks++; if ({ar_valid, aw_valid, trans_req_o, atop_req_o, ar_id} !== {4'b1010, 3'd4}) begin errors++; $display("FAIL at_rd got ar %b aw %b trans %b atop %b id %0d exp 1 0 1 0 4", ar_valid, aw_valid, trans_req_o, atop_req_o, ar_id); end
      tick();
   endtask

   task automatic test_reset_mid();
      rsp_valid_i = 1'b1; rsp_id_i = 5'b00001;
      tick();
      rsp_valid_i = 1'b0; rsp_id_i = '0;
      ar_ready = 1'b0;
      drive_req(1'b1, 5'b00001, 32'h5000, 32'h0, 4'h0, 6'h0);
      checks++; if (per_slave_gnt_o !== 1'b1) begin errors++; $display("FAIL rm_gnt got %b exp 1", per_slave_gnt_o); end
      tick();
      per_slave_req_i = 1'b0;
      tick();
      checks++; if (ar_valid !== 1'b1 || ar_addr !== 32'h5000) begin errors++; $display("FAIL rm_hold got v %b addr %h exp 1 5000", ar_valid, ar_addr); end
      #2;
      rst_i = 1'b1;
      #1;
      checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL rm_async got %b exp 0", ar_valid); end
      tick();
      rst_i = 1'b0;
      ar_ready = 1'b1;
      drive_req(1'b1, 5'b00100, 32'h6000, 32'h0, 4'h0, 6'h0);
      checks++; if (per_slave_gnt_o !== 1'b1) begin errors++; $display("FAIL rm_busy_clr got %b exp 1", per_slave_gnt_o); end
      tick();
      per_slave_req_i = 1'b0;
      checks++; if ({ar_valid, ar_addr, ar_id} !== {1'b1, 32'h6000, 3'd2}) begin errors++; $display("FAIL rm_next got v %b addr %h id %0d exp 1 6000 2", ar_valid, ar_addr, ar_id); end
      tick();
   endtask

   initial begin
      test_reset();
      test_read();
      test_busy();
      test_write();
      test_atomic();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
